// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the programmable clock divider scheduler.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W_DEF = 8;
  localparam int CLKDIV_PCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } state_t;

endpackage

// File: rtl/clkdiv_half_counter.sv
// Half-period counter: counts to cur_half, toggles div_out and strobes tick on each rise.
// Also owns the in-use half-period register, loaded by the scheduler FSM.
module clkdiv_half_counter #(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  output logic [CNT_W-1:0] cur_half,
  output logic             div_out,
  output logic             tick,
  output logic             match
);

  logic [CNT_W-1:0] cnt;

  assign match = (cnt == cur_half);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else if (run) begin
      if (match) begin
        cnt     <= '0;
        div_out <= ~div_out;
        tick    <= ~div_out;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // A load coinciding with a terminal count takes effect for the next phase only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_half <= CNT_W'(DEF_HALF);
    end else if (load) begin
      cur_half <= load_half;
    end
  end

endmodule

// File: rtl/clk_div_scheduler.sv
// Run-time programmable even-ratio clock divider with glitch-free ratio change and start/stop.
// Optional completed-period counter enabled by defining CLKDIV_PERIOD_CNT_EN.
module clk_div_scheduler
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = CLKDIV_CNT_W_DEF,
  parameter int DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [CLKDIV_PCNT_W-1:0] period_cnt
`endif
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pend_half;
  logic [CNT_W-1:0] load_half;
  logic             accept;
  logic             run, clear, load;
  logic             match, boundary;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign boundary  = match & div_out;

  // pend_half tracks cur_half whenever no change is outstanding, so every exit may load it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend_half <= CNT_W'(DEF_HALF);
    end else begin
      state <= state_nxt;
      if (accept) pend_half <= cfg_half;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    clear     = 1'b0;
    load      = 1'b0;
    load_half = pend_half;
    unique case (state)
      IDLE: begin
        clear = 1'b1;
        if (accept) begin
          load      = 1'b1;
          load_half = cfg_half;
        end
        if (en) state_nxt = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (!en)         state_nxt = STOP;
        else if (accept) state_nxt = PEND;
      end
      PEND: begin
        run = 1'b1;
        if (boundary) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
        if (!en) state_nxt = STOP;
      end
      STOP: begin
        // Low phase is already safe to cut; a high phase must run to its full length.
        if (!div_out) begin
          clear     = 1'b1;
          load      = 1'b1;
          state_nxt = IDLE;
        end else begin
          run = 1'b1;
          if (boundary) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  clkdiv_half_counter #(
    .CNT_W   (CNT_W),
    .DEF_HALF(DEF_HALF)
  ) u_half_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (clear),
    .load     (load),
    .load_half(load_half),
    .cur_half (cur_half),
    .div_out  (div_out),
    .tick     (tick),
    .match    (match)
  );

`ifdef CLKDIV_PERIOD_CNT_EN
  logic                     fall;
  logic [CLKDIV_PCNT_W-1:0] pcnt;

  assign fall       = run & boundary;
  assign period_cnt = pcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (fall) begin
      pcnt <= pcnt + CLKDIV_PCNT_W'(1);
    end
  end
`endif

endmodule
